// File: rtl/key_arbiter.sv
// Round-robin arbiter for ten key requesters with an acknowledge handshake,
// a timeout on unacknowledged grants, and registered one-hot / binary grant outputs.
module key_arbiter #(
    parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [9:0] iREQ,
    input  logic       iACK,
    output logic [9:0] oGNT,
    output logic [3:0] oCODE,
    output logic       oVALID,
    output logic       oBUSY,
    output logic       oTOUT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] NO_CODE  = 4'b1111;
    localparam logic [3:0] LAST_KEY = 4'd9;

    state_t      state_r;
    logic [3:0]  ptr_r;
    logic [7:0]  wait_r;
    logic [9:0]  gnt_r;
    logic [3:0]  code_r;
    logic        valid_r;
    logic        busy_r;
    logic        tout_r;

    logic [3:0]  pick_s;
    logic        held_s;
    logic        tout_hit_s;
    logic        exit_s;
    logic        tout_fire_s;

    function automatic logic [3:0] wrap_inc(input logic [3:0] v);
        logic [3:0] r;
        if (v >= LAST_KEY) begin
            r = 4'd0;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

    // First set request bit at or after ptr, wrapping 9 -> 0.
    function automatic logic [3:0] rr_pick(input logic [9:0] req, input logic [3:0] ptr);
        logic [4:0] idx;
        logic       found;
        logic [3:0] r;
        r     = NO_CODE;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            idx = {1'b0, ptr} + 5'(i);
            if (idx >= 5'd10) begin
                idx = idx - 5'd10;
            end else begin
                idx = idx;
            end
            if (!found && req[idx[3:0]]) begin
                r     = idx[3:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return r;
    endfunction

    function automatic logic [9:0] key_onehot(input logic [3:0] code);
        return 10'd1 << code;
    endfunction

    // Arbitration candidate and exit conditions for the current cycle
    always_comb begin
        pick_s      = rr_pick(iREQ, ptr_r);
        held_s      = |(iREQ & gnt_r);
        tout_hit_s  = (wait_r == (ACK_TIMEOUT - 8'd1));
        exit_s      = 1'b0;
        tout_fire_s = 1'b0;
        case (state_r)
            GRANT: begin
                if (iACK) begin
                    exit_s = 1'b0;
                end else if (!held_s) begin
                    exit_s = 1'b1;
                end else if (tout_hit_s) begin
                    exit_s      = 1'b1;
                    tout_fire_s = 1'b1;
                end else begin
                    exit_s = 1'b0;
                end
            end
            HOLD: begin
                exit_s = !held_s;
            end
            default: begin
                exit_s = 1'b0;
            end
        endcase
    end

    // Arbiter state machine with registered grant outputs
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_r <= IDLE;
            ptr_r   <= 4'd0;
            wait_r  <= 8'd0;
            gnt_r   <= 10'd0;
            code_r  <= NO_CODE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            tout_r  <= 1'b0;
        end else if (exit_s) begin
            // Every release moves the pointer past the key that was served.
            state_r <= IDLE;
            ptr_r   <= wrap_inc(code_r);
            wait_r  <= 8'd0;
            gnt_r   <= 10'd0;
            code_r  <= NO_CODE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            tout_r  <= tout_fire_s;
        end else begin
            tout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (iREQ != 10'd0) begin
                        state_r <= GRANT;
                        wait_r  <= 8'd0;
                        gnt_r   <= key_onehot(pick_s);
                        code_r  <= pick_s;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        gnt_r   <= 10'd0;
                        code_r  <= NO_CODE;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (iACK) begin
                        state_r <= HOLD;
                        valid_r <= 1'b0;
                    end else begin
                        wait_r <= wait_r + 8'd1;
                    end
                end
                HOLD: begin
                    state_r <= HOLD;
                end
                default: begin
                    state_r <= IDLE;
                    wait_r  <= 8'd0;
                    gnt_r   <= 10'd0;
                    code_r  <= NO_CODE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign oGNT   = gnt_r;
    assign oCODE  = code_r;
    assign oVALID = valid_r;
    assign oBUSY  = busy_r;
    assign oTOUT  = tout_r;

endmodule

// Output invariants of key_arbiter, observed from its ports.
module key_arbiter_checker (
    input logic       clk,
    input logic       rst,
    input logic [9:0] gnt,
    input logic [3:0] code,
    input logic       valid,
    input logic       busy,
    input logic       tout
);

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

    a_code_matches: assert property (@(posedge clk) disable iff (rst)
        (gnt == 10'd0) ? (code == 4'b1111) : (gnt == (10'd1 << code)));

    a_busy_tracks_grant: assert property (@(posedge clk) disable iff (rst)
        busy == (gnt != 10'd0));

    a_valid_needs_busy: assert property (@(posedge clk) disable iff (rst) valid |-> busy);

    a_tout_idle: assert property (@(posedge clk) disable iff (rst) tout |-> !busy);

    a_tout_pulse: assert property (@(posedge clk) disable iff (rst) tout |=> !tout);

endmodule
